// File: rtl/store_write_unit.sv
// Store write unit: formats committed stores into lane-aligned SRAM writes
// through a 2-entry FIFO and tracks writes outstanding at the SRAM.
module store_write_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        idle
);

  typedef enum logic [2:0] {
    OP_SB  = 3'd0,
    OP_SH  = 3'd1,
    OP_SW  = 3'd2,
    OP_SWL = 3'd3,
    OP_SWR = 3'd4
  } st_op_e;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t       fifo [2];
  req_t       fmt;
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic [1:0] outstanding;
  logic       push, pop, retire;

  always_comb begin
    fmt.size  = 2'd2;
    fmt.addr  = {st_addr[31:2], 2'b00};
    fmt.wstrb = '0;
    fmt.wdata = st_data;
    case (st_op_e'(st_op))
      OP_SB: begin
        fmt.size  = 2'd0;
        fmt.addr  = st_addr;
        fmt.wstrb = 4'b0001 << st_addr[1:0];
        fmt.wdata = {4{st_data[7:0]}};
      end
      OP_SH: begin
        fmt.size  = 2'd1;
        fmt.addr  = st_addr;
        fmt.wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt.wdata = {2{st_data[15:0]}};
      end
      OP_SW: fmt.wstrb = '1;
      OP_SWL: begin
        case (st_addr[1:0])
          2'd0:    begin fmt.wstrb = 4'b0001; fmt.wdata = st_data >> 24; end
          2'd1:    begin fmt.wstrb = 4'b0011; fmt.wdata = st_data >> 16; end
          2'd2:    begin fmt.wstrb = 4'b0111; fmt.wdata = st_data >> 8;  end
          default: begin fmt.wstrb = 4'b1111; fmt.wdata = st_data;       end
        endcase
      end
      OP_SWR: begin
        case (st_addr[1:0])
          2'd0:    begin fmt.wstrb = 4'b1111; fmt.wdata = st_data;       end
          2'd1:    begin fmt.wstrb = 4'b1110; fmt.wdata = st_data << 8;  end
          2'd2:    begin fmt.wstrb = 4'b1100; fmt.wdata = st_data << 16; end
          default: begin fmt.wstrb = 4'b1000; fmt.wdata = st_data << 24; end
        endcase
      end
      default: ; // illegal op: still issued, but writes no lanes
    endcase
  end

  // Outputs are forced to their idle values while reset is held.
  assign st_ready   = reset || (count < 2'd2);
  assign data_req   = !reset && (count != 2'd0) && (outstanding < 2'd2);
  assign data_wr    = 1'b1;
  assign data_size  = fifo[rd_ptr].size;
  assign data_addr  = fifo[rd_ptr].addr;
  assign data_wstrb = fifo[rd_ptr].wstrb;
  assign data_wdata = fifo[rd_ptr].wdata;
  assign idle       = reset || ((count == 2'd0) && (outstanding == 2'd0));

  assign push   = st_valid && (count < 2'd2);
  assign pop    = data_req && data_addr_ok;
  assign retire = data_data_ok && (outstanding != 2'd0);

  always_comb begin
    ld_hazard = (outstanding != 2'd0);
    if ((count != 2'd0) && (fifo[rd_ptr].addr[31:2] == ld_addr[31:2]))
      ld_hazard = 1'b1;
    if ((count == 2'd2) && (fifo[!rd_ptr].addr[31:2] == ld_addr[31:2]))
      ld_hazard = 1'b1;
    if (reset)
      ld_hazard = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      fifo[wr_ptr] <= fmt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      outstanding <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
      case ({pop, retire})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
